// File: rtl/cc_timer_pkg.sv
// Shared encodings and constants for the timestamp-driven timeout blocks.
package cc_timer_pkg;

  typedef enum logic [1:0] {
    UNIT_NS = 2'd0,
    UNIT_US = 2'd1,
    UNIT_MS = 2'd2,
    UNIT_S  = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int RADIX_SUB = 1000;
  localparam int FIELD_MAX = 999;

  // Seconds roll over at the natural field width; sub-second fields roll at 1000.
  function automatic logic is_full_radix(unit_e u);
    return u == UNIT_S;
  endfunction

endpackage

// File: rtl/cc_timeout_monitor_if.sv
// Control, timestamp and status bundle of cc_timeout_monitor.
interface cc_timeout_monitor_if #(parameter int FW = 10);

  logic          start;
  logic          cancel;
  logic [FW-1:0] dur_val;
  logic [1:0]    dur_unit;
  logic [FW-1:0] nanos;
  logic [FW-1:0] micros;
  logic [FW-1:0] milis;
  logic [FW-1:0] segs;
  logic          busy;
  logic          expired;
  logic          timed_out;
  logic          err;
  logic [FW:0]   remaining;

  modport master (
    output start, cancel, dur_val, dur_unit, nanos, micros, milis, segs,
    input  busy, expired, timed_out, err, remaining
  );

  modport slave (
    input  start, cancel, dur_val, dur_unit, nanos, micros, milis, segs,
    output busy, expired, timed_out, err, remaining
  );

endinterface

// File: rtl/tm_field_delta.sv
// Modular forward distance from prev to cur for a wrapping timestamp field.
module tm_field_delta
  import cc_timer_pkg::*;
#(
  parameter int FW = 10
) (
  input  logic [FW-1:0] cur,
  input  logic [FW-1:0] prev,
  input  logic          full_radix,
  output logic [FW-1:0] delta
);

  always_comb begin
    delta = cur - prev;
    // A radix-1000 field that went "backwards" wrapped through 999 -> 0.
    if (!full_radix && (cur < prev)) begin
      delta = FW'(({1'b0, cur} + (FW+1)'(RADIX_SUB)) - {1'b0, prev});
    end
  end

endmodule

// File: rtl/cc_timeout_monitor.sv
// Counts a requested duration down against an external free-running time counter.
module cc_timeout_monitor
  import cc_timer_pkg::*;
#(
  parameter int FW      = 10,
  parameter int MAX_DUR = 999
) (
  input  logic                 CLK,
  input  logic                 reset,
  cc_timeout_monitor_if.slave  bus
);

  localparam logic [FW-1:0] MAX_DUR_V = FW'(MAX_DUR);

  state_e        state_q, state_d;
  unit_e         unit_q, unit_d;
  logic [FW-1:0] prev_q, prev_d;
  logic [FW:0]   rem_q, rem_d;
  logic          exp_q, exp_d;
  logic          to_q, to_d;
  logic          err_q, err_d;
  logic [FW-1:0] run_field, arm_field, delta;

  function automatic logic [FW-1:0] pick(unit_e u, logic [FW-1:0] ns, logic [FW-1:0] us,
                                         logic [FW-1:0] ms, logic [FW-1:0] s);
    case (u)
      UNIT_NS: return ns;
      UNIT_US: return us;
      UNIT_MS: return ms;
      default: return s;
    endcase
  endfunction

  assign run_field = pick(unit_q, bus.nanos, bus.micros, bus.milis, bus.segs);
  assign arm_field = pick(unit_e'(bus.dur_unit), bus.nanos, bus.micros, bus.milis, bus.segs);

  tm_field_delta #(.FW(FW)) u_delta (
    .cur        (run_field),
    .prev       (prev_q),
    .full_radix (is_full_radix(unit_q)),
    .delta      (delta)
  );

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    prev_d  = prev_q;
    rem_d   = rem_q;
    exp_d   = 1'b0;
    to_d    = to_q;
    err_d   = 1'b0;
    if (bus.cancel) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      to_d    = 1'b0;
    end else if (bus.start && (bus.dur_val > MAX_DUR_V)) begin
      // Rejected request: everything else holds, including prev, so no time is lost.
      err_d = 1'b1;
    end else if (bus.start) begin
      unit_d = unit_e'(bus.dur_unit);
      prev_d = arm_field;
      if (bus.dur_val == '0) begin
        state_d = ST_DONE;
        rem_d   = '0;
        exp_d   = 1'b1;
        to_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
        rem_d   = {1'b0, bus.dur_val};
        to_d    = 1'b0;
      end
    end else if (state_q == ST_RUN) begin
      prev_d = run_field;
      if (rem_q <= {1'b0, delta}) begin
        state_d = ST_DONE;
        rem_d   = '0;
        exp_d   = 1'b1;
        to_d    = 1'b1;
      end else begin
        rem_d = rem_q - {1'b0, delta};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      unit_q  <= UNIT_NS;
      prev_q  <= '0;
      rem_q   <= '0;
      exp_q   <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      prev_q  <= prev_d;
      rem_q   <= rem_d;
      exp_q   <= exp_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.expired   = exp_q;
  assign bus.timed_out = to_q;
  assign bus.err       = err_q;
  assign bus.remaining = rem_q;

endmodule

// File: doc/cc_timeout_monitor.md
CC_TIMEOUT_MONITOR -- requirements
Module: cc_timeout_monitor

Interface
REQ-001 Parameter FW, default 10: width of each timestamp field and of dur_val.
REQ-002 Parameter MAX_DUR, default 999: largest legal dur_val.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  arm or re-arm the timeout with dur_val and dur_unit.
REQ-006 cancel  input  1  abort a running timeout without expiry.
REQ-007 dur_val  input  FW  timeout length in units; legal range 0..MAX_DUR.
REQ-008 dur_unit  input  2  unit: 0=nanos, 1=micros, 2=milis, 3=segs.
REQ-009 nanos, micros, milis, segs  input  FW each  timestamp fields from the upstream time counter.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 expired  output  1  one-cycle pulse on timeout.
REQ-012 timed_out  output  1  sticky level, high in DONE.
REQ-013 err  output  1  one-cycle pulse when start carries dur_val > MAX_DUR.
REQ-014 remaining  output  FW+1  units left; 0 when not in RUN.

Function
REQ-015 States: IDLE, RUN and DONE; all outputs are registered.
REQ-016 Selected field: the timestamp field chosen by the latched unit.
- Radix for nanos, micros and milis: 1000.
- Radix for segs: 2^FW.
REQ-017 Each cycle in RUN, delta = (cur - prev) mod radix, where cur is the selected field and prev is its previous sample; prev then takes cur.
REQ-018 In RUN, remaining is updated to max(remaining - delta, 0).
REQ-019 When that result is 0, the block moves to DONE.
- expired = 1 for exactly the cycle after that edge.
- timed_out = 1 from that cycle onward.
REQ-020 start with 1 <= dur_val <= MAX_DUR, in any state, performs all of:
- latch the unit;
- load remaining = dur_val;
- load prev = the current selected field;
- clear timed_out;
- enter RUN; busy = 1 on the next cycle.
REQ-021 start with dur_val = 0 enters DONE directly; expired pulses on the next cycle.
REQ-022 start with dur_val > MAX_DUR:
- err pulses on the next cycle;
- state, remaining and timed_out are unchanged.
REQ-023 cancel in any state forces IDLE and clears timed_out; expired is not pulsed.
REQ-024 start and cancel in the same cycle: cancel wins.
REQ-025 Expiry edge coinciding with start: start wins; no expired pulse.
REQ-026 Deltas above 1 per cycle (field advancing on both clock edges) are counted in full.
REQ-027 A wrap of the field (999 to 0, or 1023 to 0 for segs) counts as a delta of 1.
REQ-028 A backward jump of the field (upstream counter reset) is treated as a modular delta.
- No error is flagged.
- Early expiry is acceptable.
REQ-029 Timing accuracy: expiry occurs after more than dur_val-1 and at most dur_val full unit periods of the selected field.
REQ-030 In IDLE and DONE, timestamp inputs are ignored.

Reset
REQ-031 When reset = 1 at a posedge, the block shall enter IDLE and clear all of the following:
- busy, expired, timed_out, err;
- remaining;
- prev and the latched unit.
REQ-032 Reset overrides start and cancel; reset mid-RUN discards the timeout with no expired pulse.

Structure
REQ-033 Shared package cc_timer_pkg holds:
- unit encodings UNIT_NS, UNIT_US, UNIT_MS, UNIT_S;
- state encodings ST_IDLE, ST_RUN, ST_DONE;
- constants RADIX_SUB = 1000 and FIELD_MAX = 999.
REQ-034 One sub-module, tm_field_delta, is natural.
- It is combinational.
- It computes the modular difference of two FW-bit fields for a given radix.
- cc_timeout_monitor instantiates it once.

Verification
REQ-035 Run: start with dur_val = 5, dur_unit = 1, micros = 10.
- Required: expired pulses exactly once, on the cycle after the edge where micros = 15 is sampled.
- Required: busy falls at the same time; remaining steps 5,4,3,2,1,0.
REQ-036 Wrap: start with dur_val = 3, dur_unit = 2, milis = 998.
- Required: expiry after milis samples 999, 0, 1.
- Required: no early expiry at the wrap.
REQ-037 Multi-step delta: start with dur_val = 10, dur_unit = 0; nanos advances by 2 per cycle.
- Required: expired on the 5th cycle after arming.
REQ-038 Cancel and collisions:
- cancel at remaining = 2: IDLE, no expired pulse.
- start and cancel in the same cycle: IDLE.
- start in DONE: timed_out clears and busy = 1.
REQ-039 Edge values:
- dur_val = 0: expired on the next cycle.
- dur_val = 1000: err pulse and state unchanged.
- reset asserted mid-RUN: all outputs 0 on the next cycle.
